vga_timing_gen: RTL

- Raster timing generator that sits directly upstream of the nyancat pixel renderer.
- Produces pixel coordinates, active-video qualifier, horizontal/vertical sync and frame/line strobes in the px_clk domain.
- Optionally realigns sync and active-video to the renderer's 2-cycle pixel pipeline so the pins see colour and sync on the same edge.
- Default mode: 640x480@72Hz, 31.5 MHz px_clk.

---
 rtl/vga_timing_gen_pkg.sv | 42 ++++
 rtl/vga_timing_gen_axis.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing constants, coordinate widths and phase encoding
// for the vga_timing_gen slice (640x480@72Hz default mode).
package vga_timing_gen_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 40;
  localparam int H_BP_DEF     = 128;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF
                              + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 9;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 28;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF
                              + V_SYNC_DEF + V_BP_DEF;

  localparam int X_COORD_WIDTH = $clog2(H_TOTAL_DEF);
  localparam int Y_COORD_WIDTH = $clog2(V_TOTAL_DEF);

  localparam bit HSYNC_POL_DEF  = 1'b0;
  localparam bit VSYNC_POL_DEF  = 1'b0;
  localparam int PIPE_DELAY_DEF = 2;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  // Phase a counter value belongs to; the FSM must always agree with it.
  function automatic phase_e phase_of(input int c, input int act,
                                      input int fp, input int sync);
    if (c < act) return PH_ACT;
    if (c < act + fp) return PH_FP;
    if (c < act + fp + sync) return PH_SYNC;
    return PH_BP;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping counter plus ACT/FP/SYNC/BP phase FSM.
// Advances only when adv_i is high; wrap_o flags the last count.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int W      = 10,
  parameter int ACTIVE = 640,
  parameter int FP     = 24,
  parameter int SYNC   = 40,
  parameter int BP     = 128
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         adv_i,
  output logic [W-1:0] cnt_o,
  output phase_e       phase_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] ACT_END  = W'(ACTIVE - 1);
  localparam logic [W-1:0] FP_END   = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] LAST     = W'(ACTIVE + FP + SYNC + BP - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  phase_e       phase_q;
  logic         last;

  assign last   = (cnt_q == LAST);
  assign cnt_d  = last ? '0 : cnt_q + 1'b1;
  assign wrap_o = adv_i & last;

  assign cnt_o   = cnt_q;
  assign phase_o = phase_q;

  // Counter and phase FSM step together on each advance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= PH_ACT;
    end else if (adv_i) begin
      cnt_q <= cnt_d;
      unique case (phase_q)
        PH_ACT:  if (cnt_q == ACT_END)  phase_q <= PH_FP;
        PH_FP:   if (cnt_q == FP_END)   phase_q <= PH_SYNC;
        PH_SYNC: if (cnt_q == SYNC_END) phase_q <= PH_BP;
        PH_BP:   if (last)              phase_q <= PH_ACT;
      endcase
    end
  end

  // Phase state and counter range must never disagree.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (phase_q == phase_of(int'(cnt_q), ACTIVE, FP, SYNC));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator feeding the nyancat pixel renderer.
// Optional macro VGA_TIMING_SYNC_ALIGN_EN delays the pin signals by PIPE_DELAY.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit HSYNC_POL  = HSYNC_POL_DEF,
  parameter bit VSYNC_POL  = VSYNC_POL_DEF,
  parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
  input  logic                     px_clk,
  input  logic                     reset_n,
  output logic [X_COORD_WIDTH-1:0] x_px,
  output logic [Y_COORD_WIDTH-1:0] y_px,
  output logic                     activevideo,
  output logic                     line_start,
  output logic                     frame_start,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     activevideo_pin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic HS_ON  = HSYNC_POL;
  localparam logic HS_OFF = ~HSYNC_POL;
  localparam logic VS_ON  = VSYNC_POL;
  localparam logic VS_OFF = ~VSYNC_POL;

  localparam logic [2:0] PIN_IDLE = {HS_OFF, VS_OFF, 1'b0};

  if (H_TOTAL > (1 << X_COORD_WIDTH) ||
      V_TOTAL > (1 << Y_COORD_WIDTH)) begin : g_bad_width
    $error("vga_timing_gen: totals exceed coordinate width");
  end

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_len
    $error("vga_timing_gen: zero-length timing segment");
  end

  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DELAY out of range 0..7");
  end

  logic [X_COORD_WIDTH-1:0] h_cnt;
  logic [Y_COORD_WIDTH-1:0] v_cnt;
  phase_e                   h_ph;
  phase_e                   v_ph;
  logic                     h_wrap;
  logic                     v_wrap_unused;

  vga_axis_counter #(
    .W      (X_COORD_WIDTH),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk_i   (px_clk),
    .rst_ni  (reset_n),
    .adv_i   (1'b1),
    .cnt_o   (h_cnt),
    .phase_o (h_ph),
    .wrap_o  (h_wrap)
  );

  vga_axis_counter #(
    .W      (Y_COORD_WIDTH),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk_i   (px_clk),
    .rst_ni  (reset_n),
    .adv_i   (h_wrap),
    .cnt_o   (v_cnt),
    .phase_o (v_ph),
    .wrap_o  (v_wrap_unused)
  );

  logic [X_COORD_WIDTH-1:0] x_q;
  logic [Y_COORD_WIDTH-1:0] y_q;
  logic                     av_q;
  logic                     ls_q;
  logic                     fs_q;
  logic                     hs_q;
  logic                     vs_q;

  // Register every output from the current counter and phase state.
  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      av_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      hs_q <= HS_OFF;
      vs_q <= VS_OFF;
    end else begin
      x_q  <= h_cnt;
      y_q  <= v_cnt;
      av_q <= (h_ph == PH_ACT) && (v_ph == PH_ACT);
      ls_q <= (h_cnt == '0);
      fs_q <= (h_cnt == '0) && (v_cnt == '0);
      hs_q <= (h_ph == PH_SYNC) ? HS_ON : HS_OFF;
      vs_q <= (v_ph == PH_SYNC) ? VS_ON : VS_OFF;
    end
  end

  logic [2:0] pin_d;
  logic [2:0] pin_out;

  assign pin_d = {hs_q, vs_q, av_q};

`ifdef VGA_TIMING_SYNC_ALIGN_EN
  if (PIPE_DELAY == 0) begin : g_nodly
    assign pin_out = pin_d;
  end else begin : g_dly
    logic [2:0] dly_q [PIPE_DELAY];

    // Shift pin signals so they land with the renderer's colour output.
    always_ff @(posedge px_clk) begin
      if (!reset_n) begin
        for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= PIN_IDLE;
      end else begin
        dly_q[0] <= pin_d;
        for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign pin_out = dly_q[PIPE_DELAY-1];
  end
`else
  assign pin_out = pin_d;
`endif

  assign x_px        = x_q;
  assign y_px        = y_q;
  assign activevideo = av_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  assign {hsync, vsync, activevideo_pin} = pin_out;

endmodule
